updown_counter: RTL and testbench



---
 rtl/updown_counter.sv | 98 +++++++++
 tb/tb_updown_counter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter.sv
// Up/down modulo counter with an enable prescaler, synchronous clear/load and a registered wrap pulse.
// Define UPDOWN_COUNTER_SATURATE_EN to make boundary steps hold at the bound and set the sticky sat flag.
module updown_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MODULUS  = 256,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             sat
);
    localparam int unsigned       PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH:0]    CNT_MAX  = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0]  CNT_TOP  = WIDTH'(MODULUS - 1);
    localparam logic [PW-1:0]     PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]    presc;
    logic [WIDTH-1:0] count_q;
    logic             wrap_q;
    logic [WIDTH:0]   cnt_inc;
    logic [WIDTH:0]   cnt_dec;
    logic [WIDTH:0]   load_ext;
    logic             step;
    logic             at_top;
    logic             at_bot;

    // Boundaries come from the extra arithmetic bit: overshoot past the top, borrow below zero.
    always_comb begin
        cnt_inc  = {1'b0, count_q} + (WIDTH+1)'(1);
        cnt_dec  = {1'b0, count_q} - (WIDTH+1)'(1);
        load_ext = {1'b0, load_val};
        step     = en && (presc == PRE_LAST);
        at_top   = (cnt_inc > CNT_MAX);
        at_bot   = cnt_dec[WIDTH];
    end

`ifdef UPDOWN_COUNTER_SATURATE_EN
    logic sat_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            presc   <= '0;
            wrap_q  <= 1'b0;
`ifdef UPDOWN_COUNTER_SATURATE_EN
            sat_q   <= 1'b0;
`endif
        end else if (clr) begin
            count_q <= '0;
            presc   <= '0;
            wrap_q  <= 1'b0;
`ifdef UPDOWN_COUNTER_SATURATE_EN
            sat_q   <= 1'b0;
`endif
        end else if (load) begin
            count_q <= (load_ext > CNT_MAX) ? CNT_TOP : load_val;
            presc   <= '0;
            wrap_q  <= 1'b0;
`ifdef UPDOWN_COUNTER_SATURATE_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            wrap_q <= 1'b0;
            if (en) begin
                presc <= step ? '0 : presc + PW'(1);
            end
            if (step) begin
                if (up_dn ? at_top : at_bot) begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
                    sat_q   <= 1'b1;
`else
                    count_q <= up_dn ? '0 : CNT_TOP;
                    wrap_q  <= 1'b1;
`endif
                end else begin
                    count_q <= up_dn ? cnt_inc[WIDTH-1:0] : cnt_dec[WIDTH-1:0];
                end
            end
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
`ifdef UPDOWN_COUNTER_SATURATE_EN
    assign sat   = sat_q;
`else
    assign sat   = 1'b0;
`endif

endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench for updown_counter: a behavioural model queues expected {sat,wrap,count} per edge.
// Instance a: MODULUS=10, PRESCALE=3; instance b: MODULUS=256, PRESCALE=1. Honours UPDOWN_COUNTER_SATURATE_EN.
module tb_updown_counter;

`ifdef UPDOWN_COUNTER_SATURATE_EN
    localparam bit SAT_MODE = 1'b1;
`else
    localparam bit SAT_MODE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       a_en, a_up, a_clr, a_load;
    logic [7:0] a_lv;
    logic [7:0] a_count;
    logic       a_wrap, a_sat;
    logic       b_en, b_up, b_clr, b_load;
    logic [7:0] b_lv;
    logic [7:0] b_count;
    logic       b_wrap, b_sat;

    int n_vec = 0;
    int n_err = 0;

    logic [9:0] q_a[$];
    logic [9:0] q_b[$];
    int mc[2];
    int mp[2];
    int mw[2];
    int ms[2];

    updown_counter #(.WIDTH(8), .MODULUS(10), .PRESCALE(3)) dut_a (
        .clk(clk), .rst(rst), .en(a_en), .up_dn(a_up), .clr(a_clr), .load(a_load),
        .load_val(a_lv), .count(a_count), .wrap(a_wrap), .sat(a_sat)
    );

    updown_counter #(.WIDTH(8), .MODULUS(256), .PRESCALE(1)) dut_b (
        .clk(clk), .rst(rst), .en(b_en), .up_dn(b_up), .clr(b_clr), .load(b_load),
        .load_val(b_lv), .count(b_count), .wrap(b_wrap), .sat(b_sat)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mc[i] = 0;
            mp[i] = 0;
            mw[i] = 0;
            ms[i] = 0;
        end
    endtask

    task automatic model(input int id, input logic en, input logic up, input logic clr,
                         input logic load, input logic [7:0] lv, input int m, input int p);
        if (clr) begin
            mc[id] = 0; mp[id] = 0; mw[id] = 0; ms[id] = 0;
        end else if (load) begin
            mc[id] = (int'(lv) > m - 1) ? m - 1 : int'(lv);
            mp[id] = 0; mw[id] = 0; ms[id] = 0;
        end else begin
            mw[id] = 0;
            if (en) begin
                if (mp[id] == p - 1) begin
                    mp[id] = 0;
                    if ((up && mc[id] == m - 1) || (!up && mc[id] == 0)) begin
                        if (SAT_MODE) begin
                            ms[id] = 1;
                        end else begin
                            mc[id] = up ? 0 : m - 1;
                            mw[id] = 1;
                        end
                    end else begin
                        mc[id] = up ? mc[id] + 1 : mc[id] - 1;
                    end
                end else begin
                    mp[id] = mp[id] + 1;
                end
            end
        end
    endtask

    function automatic logic [9:0] expv(input int id);
        logic [7:0] c;
        c = 8'(mc[id]);
        return {ms[id] != 0, mw[id] != 0, c};
    endfunction

    // Model the coming edge, queue the expectation, then compare once the edge has happened.
    task automatic tick(input string tag);
        model(0, a_en, a_up, a_clr, a_load, a_lv, 10, 3);
        q_a.push_back(expv(0));
        model(1, b_en, b_up, b_clr, b_load, b_lv, 256, 1);
        q_b.push_back(expv(1));
        @(posedge clk);
        #1;
        check({tag, "/a"}, {22'd0, a_sat, a_wrap, a_count}, {22'd0, q_a.pop_front()});
        check({tag, "/b"}, {22'd0, b_sat, b_wrap, b_count}, {22'd0, q_b.pop_front()});
    endtask

    task automatic idle();
        a_en = 0; a_up = 0; a_clr = 0; a_load = 0; a_lv = 0;
        b_en = 0; b_up = 0; b_clr = 0; b_load = 0; b_lv = 0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        #2;
        check("reset/a", {22'd0, a_sat, a_wrap, a_count}, 32'd0);
        check("reset/b", {22'd0, b_sat, b_wrap, b_count}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Count up 30 enabled cycles: step every third, wrap at the end.
        a_en = 1; a_up = 1;
        for (int i = 1; i <= 30; i++) begin
            tick("up30");
            if (i == 27) check("up30_cnt27", {24'd0, a_count}, 32'd9);
        end

        // Down from 0 across the lower boundary.
        a_up = 0;
        repeat (4) tick("down_wrap");

        // Load top value, then push upward past it.
        idle(); a_load = 1; a_lv = 8'd9;
        tick("load9");
        a_load = 0; a_en = 1; a_up = 1;
        repeat (6) tick("top_push");
        idle(); a_clr = 1;
        tick("clr");

        // Load clamping and priority.
        idle(); a_load = 1; a_lv = 8'd200;
        tick("load200");
        check("load200_clamp", {24'd0, a_count}, 32'd9);
        a_clr = 1; a_lv = 8'd5;
        tick("clr_over_load");
        a_clr = 0; a_en = 1; a_up = 1; a_lv = 8'd4;
        tick("load_over_en");
        a_load = 0;
        repeat (3) tick("presc_after_load");

        // Gapped enable: step only after the third enabled cycle.
        a_en = 1; tick("gap1");
        a_en = 0; tick("gap2");
        a_en = 0; tick("gap3");
        a_en = 1; tick("gap4");
        a_en = 1; tick("gap5");
        tick("gap6");

        // Asynchronous reset mid-prescale, between edges.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst/a", {22'd0, a_sat, a_wrap, a_count}, 32'd0);
        check("async_rst/b", {22'd0, b_sat, b_wrap, b_count}, 32'd0);
        model_reset();
        #1;
        rst = 1'b0;
        repeat (3) tick("after_rst");

        // Direction flip mid-prescale: direction at the stepping edge wins.
        a_up = 1; tick("dir1");
        a_up = 0; tick("dir2");
        a_up = 0; tick("dir3");
        a_up = 1; repeat (3) tick("dir4");

        // Randomised mix including clears and loads.
        for (int i = 0; i < 200; i++) begin
            a_en   = ($urandom_range(0, 3) != 0);
            a_up   = 1'($urandom_range(0, 1));
            a_clr  = ($urandom_range(0, 31) == 0);
            a_load = ($urandom_range(0, 15) == 0);
            a_lv   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
            tick("rand");
        end

        // Instance b: full 0..255 sweep with PRESCALE=1, then wrap downward.
        idle();
        b_en = 1; b_up = 1;
        for (int i = 1; i <= 257; i++) begin
            tick("b_sweep");
            if (i == 255) check("b_sweep_cnt255", {24'd0, b_count}, 32'd255);
        end
        b_up = 0;
        repeat (3) tick("b_down");
        b_en = 0; b_load = 1; b_lv = 8'd255;
        tick("b_load255");
        b_load = 0; b_en = 1; b_up = 1;
        repeat (2) tick("b_top");

        idle();
        tick("final");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
